// File: rtl/object_position_integrator.sv
// Sub-pixel position integrator for one flying object: spawn, fly under a signed velocity, report exit.
// Optional side-wall reflection is enabled by defining OBJ_BOUNCE_EN.
module object_position_integrator #(
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int FRAC_BITS = 4,
   parameter int OBJ_SIZE  = 64,
   parameter int TOP_LIMIT = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        moveclk,
   input  logic        spawn,
   input  logic [9:0]  initx,
   input  logic [9:0]  inity,
   input  logic [9:0]  vx,
   input  logic [9:0]  vy,
   input  logic [1:0]  vdx,
   input  logic [1:0]  vdy,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        active,
   output logic        exited,
   output logic        bounce,
   output logic [1:0]  state_dbg
);

   localparam int PW = 11 + FRAC_BITS;

   localparam logic signed [10:0] X_HI  = 11'(SCREEN_W);
   localparam logic signed [10:0] X_LO  = 11'(-OBJ_SIZE);
   localparam logic signed [10:0] Y_HI  = 11'(SCREEN_H);
   localparam logic signed [10:0] Y_TOP = 11'(-TOP_LIMIT);
   localparam logic signed [PW-1:0] PY_SAT    = PW'(-(TOP_LIMIT * (2 ** FRAC_BITS)));
   localparam logic signed [PW-1:0] PX_RIGHT  = PW'((SCREEN_W - 1) * (2 ** FRAC_BITS));

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FLY  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic signed [PW-1:0]  px_q, px_d;
   logic signed [PW-1:0]  py_q, py_d;
   logic                  xinv_q, xinv_d;
   logic                  bounce_q, bounce_d;

   logic signed [PW-1:0]  vx_ext, vy_ext;
   logic signed [PW-1:0]  step_x, step_y;
   logic signed [10:0]    nx, ny;
   logic                  dir_x;
   logic                  exit_x, exit_y;
   logic                  hit_left, hit_right;

   assign vx_ext = $signed({{(PW-10){1'b0}}, vx});
   assign vy_ext = $signed({{(PW-10){1'b0}}, vy});

   // Candidate step; the exit and clamp checks look at its integer part.
   always_comb begin
      dir_x  = vdx[0] ^ xinv_q;
      step_x = px_q;
      step_y = py_q;
      if (vdx[1]) begin
         step_x = dir_x ? (px_q + vx_ext) : (px_q - vx_ext);
      end
      if (vdy[1]) begin
         step_y = vdy[0] ? (py_q + vy_ext) : (py_q - vy_ext);
      end
      nx        = step_x[PW-1:FRAC_BITS];
      ny        = step_y[PW-1:FRAC_BITS];
      hit_left  = (nx < 11'sd0);
      hit_right = (nx >= X_HI);
      exit_y    = (ny >= Y_HI);
`ifdef OBJ_BOUNCE_EN
      exit_x    = 1'b0;
`else
      exit_x    = (nx >= X_HI) || (nx < X_LO);
`endif
   end

   always_comb begin
      state_d  = state_q;
      px_d     = px_q;
      py_d     = py_q;
      xinv_d   = xinv_q;
      bounce_d = 1'b0;
      if (spawn) begin
         // Spawn is honoured in every state and restarts a flight in progress.
         px_d    = $signed({1'b0, initx, {FRAC_BITS{1'b0}}});
         py_d    = $signed({1'b0, inity, {FRAC_BITS{1'b0}}});
         xinv_d  = 1'b0;
         state_d = ST_FLY;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_DONE: state_d = ST_IDLE;
            ST_FLY: begin
               if (moveclk) begin
                  px_d = step_x;
                  py_d = step_y;
`ifdef OBJ_BOUNCE_EN
                  if (hit_left) begin
                     px_d     = '0;
                     xinv_d   = ~xinv_q;
                     bounce_d = 1'b1;
                  end else if (hit_right) begin
                     px_d     = PX_RIGHT;
                     xinv_d   = ~xinv_q;
                     bounce_d = 1'b1;
                  end
`endif
                  if (ny < Y_TOP) begin
                     py_d = PY_SAT;
                  end
                  if (exit_x || exit_y) begin
                     state_d = ST_DONE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         px_q     <= '0;
         py_q     <= '0;
         xinv_q   <= 1'b0;
         bounce_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         px_q     <= px_d;
         py_q     <= py_d;
         xinv_q   <= xinv_d;
         bounce_q <= bounce_d;
      end
   end

   assign x         = px_q[PW-1:FRAC_BITS];
   assign y         = py_q[PW-1:FRAC_BITS];
   assign active    = (state_q == ST_FLY);
   assign exited    = (state_q == ST_DONE);
   assign bounce    = bounce_q;
   assign state_dbg = state_q;

   // Unused-in-default-build helpers kept observable to avoid dangling logic.
   logic unused_ok;
   assign unused_ok = hit_left ^ hit_right;

endmodule

// File: tb/tb_object_position_integrator.sv
// Randomized self-checking bench for object_position_integrator against a positional reference model.
// Define OBJ_BOUNCE_EN for both RTL and bench to check the side-wall reflection build.
module tb_object_position_integrator;

   logic        clk;
   logic        rst;
   logic        moveclk;
   logic        spawn;
   logic [9:0]  initx, inity, vx, vy;
   logic [1:0]  vdx, vdy;
   logic [10:0] x, y;
   logic        active, exited, bounce;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: positions in sixteenths of a pixel, state 0=idle 1=fly 2=done.
   int m_state, m_px, m_py;
   bit m_xinv, m_bounce;

   object_position_integrator dut (
      .clk(clk), .rst(rst), .moveclk(moveclk), .spawn(spawn),
      .initx(initx), .inity(inity), .vx(vx), .vy(vy), .vdx(vdx), .vdy(vdy),
      .x(x), .y(y), .active(active), .exited(exited), .bounce(bounce),
      .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
   endtask

   task automatic model_edge();
      int dx, dy, nx, ny;
      bit leave;
      if (!rst) begin
         m_state = 0; m_px = 0; m_py = 0; m_xinv = 0; m_bounce = 0;
         return;
      end
      m_bounce = 0;
      if (spawn) begin
         m_px = int'(initx) * 16; m_py = int'(inity) * 16; m_xinv = 0; m_state = 1;
      end else if (m_state == 2) begin
         m_state = 0;
      end else if (m_state == 1 && moveclk) begin
         dx = 0; dy = 0;
         if (vdx[1]) dx = (vdx[0] ^ m_xinv) ? int'(vx) : -int'(vx);
         if (vdy[1]) dy = vdy[0] ? int'(vy) : -int'(vy);
         nx = m_px + dx;
         ny = m_py + dy;
         leave = 0;
`ifdef OBJ_BOUNCE_EN
         if ((nx >>> 4) < 0) begin
            nx = 0; m_xinv = !m_xinv; m_bounce = 1;
         end else if ((nx >>> 4) >= 640) begin
            nx = 639 * 16; m_xinv = !m_xinv; m_bounce = 1;
         end
`else
         if ((nx >>> 4) >= 640 || (nx >>> 4) < -64) leave = 1;
`endif
         if ((ny >>> 4) >= 480) leave = 1;
         if ((ny >>> 4) < -256) ny = -256 * 16;
         m_px = nx; m_py = ny;
         if (leave) m_state = 2;
      end
   endtask

   task automatic compare_all();
      check("x",      {21'b0, x},      32'((m_px >>> 4) & 32'h7ff));
      check("y",      {21'b0, y},      32'((m_py >>> 4) & 32'h7ff));
      check("active", {31'b0, active}, {31'b0, (m_state == 1)});
      check("exited", {31'b0, exited}, {31'b0, (m_state == 2)});
      check("bounce", {31'b0, bounce}, {31'b0, m_bounce});
   endtask

   // One clock: inputs are already set, model follows the edge, outputs sampled #1 later.
   task automatic step(input logic r, input logic sp, input logic mv);
      rst = r; spawn = sp; moveclk = mv;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_spawn(input int sx, input int sy);
      initx = 10'(sx); inity = 10'(sy);
      step(1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      rst = 1'b0; spawn = 1'b0; moveclk = 1'b0;
      initx = '0; inity = '0; vx = '0; vy = '0; vdx = '0; vdy = '0;
      m_state = 0; m_px = 0; m_py = 0; m_xinv = 0; m_bounce = 0;
      #2;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("reset_x", {21'b0, x}, 32'd0);
      check("reset_active", {31'b0, active}, 32'd0);

      // Basic step with one-cycle latency.
      vx = 10'd32; vdx = 2'b11; vy = 10'd48; vdy = 2'b10;
      do_spawn(320, 400);
      step(1'b1, 1'b0, 1'b1);
      check("t1_x", {21'b0, x}, 32'd322);
      check("t1_y", {21'b0, y}, 32'd397);
      check("t1_active", {31'b0, active}, 32'd1);

      // Non-moving axis holds; fractional velocity accumulates.
      vdx = 2'b01; vx = 10'd100; vdy = 2'b00;
      repeat (5) step(1'b1, 1'b0, 1'b1);
      check("t2_xhold", {21'b0, x}, 32'd322);
      vdx = 2'b00; vy = 10'd8; vdy = 2'b11;
      repeat (2) step(1'b1, 1'b0, 1'b1);
      check("t2_yadv", {21'b0, y}, 32'd398);

      // Bottom exit, then idle ignores ticks.
      vdx = 2'b00; vy = 10'd16; vdy = 2'b11;
      do_spawn(100, 479);
      step(1'b1, 1'b0, 1'b1);
      check("t3_exited", {31'b0, exited}, 32'd1);
      check("t3_yhold", {21'b0, y}, 32'd480);
      step(1'b1, 1'b0, 1'b1);
      check("t3_exit_once", {31'b0, exited}, 32'd0);
      repeat (3) step(1'b1, 1'b0, 1'b1);
      check("t3_idle_y", {21'b0, y}, 32'd480);

      // Reset mid-flight beats spawn and moveclk.
      vx = 10'd20; vdx = 2'b11; vy = 10'd20; vdy = 2'b11;
      do_spawn(200, 200);
      step(1'b1, 1'b0, 1'b1);
      initx = 10'd50; inity = 10'd60;
      step(1'b0, 1'b1, 1'b1);
      check("t4_x0", {21'b0, x}, 32'd0);
      check("t4_noexit", {31'b0, exited}, 32'd0);

      // Spawn wins over a simultaneous tick.
      do_spawn(100, 100);
      initx = 10'd300; inity = 10'd150;
      step(1'b1, 1'b1, 1'b1);
      check("t5_x", {21'b0, x}, 32'd300);
      check("t5_y", {21'b0, y}, 32'd150);

      // Right wall: reflect or exit depending on build.
      vx = 10'd32; vdx = 2'b11; vdy = 2'b00;
      do_spawn(639, 200);
      step(1'b1, 1'b0, 1'b1);
`ifdef OBJ_BOUNCE_EN
      check("t6_clamp", {21'b0, x}, 32'd639);
      check("t6_bounce", {31'b0, bounce}, 32'd1);
      step(1'b1, 1'b0, 1'b1);
      check("t6_back", {21'b0, x}, 32'd637);
`else
      check("t6_exit", {31'b0, exited}, 32'd1);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            vx  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 63));
            vy  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 63));
            vdx = 2'($urandom_range(0, 3));
            vdy = 2'($urandom_range(0, 3));
         end
         initx = 10'($urandom_range(0, 639));
         inity = 10'($urandom_range(0, 479));
         step(($urandom_range(0, 299) != 0),
              ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 1) == 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
